pr_lsq_arbiter: RTL and testbench

- Shares the single RCA load/store-queue (LSQ) port among NUM_REQ reconfigurable PR modules.
- Fair round-robin arbitration of memory requests; only one request is forwarded to the LSQ per cycle.
- Tracks outstanding loads in an in-order tag FIFO so each load result returns to the PR module that issued it.
- Sits between the PR-module LSQ interfaces and the LSQ.

---
 rtl/pr_lsq_arbiter_if.sv | 40 ++++
 rtl/pr_lsq_arbiter.sv | 140 ++++++++++++++
 tb/tb_pr_lsq_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pr_lsq_arbiter_if.sv
// Requester-side and LSQ-side signal bundle for the PR-module LSQ arbiter.
// The arbiter uses master; the PR modules and LSQ model use slave.
interface pr_lsq_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned XLEN    = 32
);
  logic [NUM_REQ*XLEN-1:0] req_addr;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ*3-1:0]    req_fn3;
  logic [NUM_REQ-1:0]      req_load;
  logic [NUM_REQ-1:0]      req_store;
  logic [NUM_REQ-1:0]      req_new_request;
  logic [NUM_REQ-1:0]      req_grant;
  logic [XLEN-1:0]         req_load_data;
  logic [NUM_REQ-1:0]      req_load_complete;

  logic [XLEN-1:0]         lsq_addr;
  logic [XLEN-1:0]         lsq_data;
  logic [2:0]              lsq_fn3;
  logic                    lsq_load;
  logic                    lsq_store;
  logic                    lsq_new_request;
  logic                    lsq_full;
  logic [XLEN-1:0]         lsq_load_data;
  logic                    lsq_load_complete;

  modport master (
    input  req_addr, req_data, req_fn3, req_load, req_store, req_new_request,
    input  lsq_full, lsq_load_data, lsq_load_complete,
    output req_grant, req_load_data, req_load_complete,
    output lsq_addr, lsq_data, lsq_fn3, lsq_load, lsq_store, lsq_new_request
  );

  modport slave (
    output req_addr, req_data, req_fn3, req_load, req_store, req_new_request,
    output lsq_full, lsq_load_data, lsq_load_complete,
    input  req_grant, req_load_data, req_load_complete,
    input  lsq_addr, lsq_data, lsq_fn3, lsq_load, lsq_store, lsq_new_request
  );
endinterface

// File: rtl/pr_lsq_arbiter.sv
// Round-robin sharing of one LSQ port among NUM_REQ PR modules, with an
// in-order tag FIFO that steers each load result back to its issuer.
module pr_lsq_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned XLEN            = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  pr_lsq_arbiter_if.master                   bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_loads,
  output logic                               protocol_error
);

  localparam int unsigned IDXW = $clog2(NUM_REQ);
  localparam int unsigned PTRW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNTW = PTRW + 1;

  logic [IDXW-1:0] rr_ptr, rr_ptr_next;
  logic [IDXW-1:0] tags [MAX_OUTSTANDING];
  logic [PTRW-1:0] wr_ptr, wr_ptr_next;
  logic [PTRW-1:0] rd_ptr, rd_ptr_next;
  logic [CNTW-1:0] count, count_next;
  logic            err, err_next;

  logic [IDXW-1:0] cand;
  logic            found;
  logic            cand_load;
  logic            cand_store;
  logic [XLEN-1:0] cand_addr;
  logic [XLEN-1:0] cand_data;
  logic [2:0]      cand_fn3;
  logic            fifo_full;
  logic            fifo_empty;
  logic            issue;
  logic            push;
  logic            pop;
  logic [IDXW-1:0] head;

  function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW-1:0] base,
                                               input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDXW'(sum);
  endfunction

  // First requesting index at or after the round-robin pointer
  always_comb begin
    cand  = rr_ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_new_request[wrap_idx(rr_ptr, k)]) begin
        found = 1'b1;
        cand  = wrap_idx(rr_ptr, k);
      end
    end
  end

  assign cand_load  = bus.req_load[cand];
  assign cand_store = bus.req_store[cand];
  assign cand_addr  = bus.req_addr[32'(cand)*XLEN +: XLEN];
  assign cand_data  = bus.req_data[32'(cand)*XLEN +: XLEN];
  assign cand_fn3   = bus.req_fn3[32'(cand)*3 +: 3];

  assign fifo_full  = (count == CNTW'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign head       = tags[rd_ptr];

  // A load with a full tag FIFO stalls arbitration, even if a pop is in flight
  assign issue = found && !bus.lsq_full && !(cand_load && fifo_full);
  assign push  = issue && cand_load;
  assign pop   = bus.lsq_load_complete && !fifo_empty;

  // Combinational port outputs, forced quiet while reset is held
  always_comb begin
    bus.req_grant         = '0;
    bus.req_load_complete = '0;
    bus.req_load_data     = bus.lsq_load_data;
    bus.lsq_new_request   = 1'b0;
    bus.lsq_addr          = cand_addr;
    bus.lsq_data          = cand_data;
    bus.lsq_fn3           = cand_fn3;
    bus.lsq_load          = 1'b0;
    bus.lsq_store         = 1'b0;
    if (rst) begin
      bus.lsq_load  = cand_load;
      bus.lsq_store = cand_store;
      if (issue) begin
        bus.lsq_new_request = 1'b1;
        bus.req_grant[cand] = 1'b1;
      end
      if (pop) bus.req_load_complete[head] = 1'b1;
    end
  end

  // Next-state for pointer, tag FIFO bookkeeping and sticky error
  always_comb begin
    rr_ptr_next = rr_ptr;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    err_next    = err;
    if (issue) rr_ptr_next = wrap_idx(cand, 1);
    if (push)  wr_ptr_next = wr_ptr + PTRW'(1);
    if (pop)   rd_ptr_next = rd_ptr + PTRW'(1);
    unique case ({push, pop})
      2'b10:   count_next = count + CNTW'(1);
      2'b01:   count_next = count - CNTW'(1);
      default: count_next = count;
    endcase
    if (bus.lsq_load_complete && fifo_empty) err_next = 1'b1;
    if (push && cand_store)                  err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      rr_ptr <= rr_ptr_next;
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      err    <= err_next;
    end
  end

  // Tag storage carries no reset; occupancy alone decides validity
  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr] <= cand;
  end

  assign outstanding_loads = count;
  assign protocol_error    = err;

endmodule

// File: tb/tb_pr_lsq_arbiter.sv
// Self-checking bench for pr_lsq_arbiter: directed scenarios plus a random
// run checked against a queue-based reference model.
module tb_pr_lsq_arbiter;

  localparam int NREQ = 4;
  localparam int MAXO = 4;

  logic       clk;
  logic       rst;
  logic [2:0] outstanding;
  logic       perr;

  int n_checks = 0;
  int n_pass   = 0;

  pr_lsq_arbiter_if #(.NUM_REQ(NREQ), .XLEN(32)) bus ();

  pr_lsq_arbiter #(.NUM_REQ(NREQ), .MAX_OUTSTANDING(MAXO), .XLEN(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus.master),
    .outstanding_loads (outstanding),
    .protocol_error    (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int   m_ptr;
  int   m_q[$];
  bit   m_err;

  // Per-cycle predictions
  bit              e_found, e_issue, e_ld, e_pop;
  int              e_win;
  logic [NREQ-1:0] e_grant, e_lc;

  task automatic model_reset();
    m_ptr = 0;
    m_q.delete();
    m_err = 1'b0;
  endtask

  function automatic void predict();
    e_found = 1'b0;
    e_win   = m_ptr;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (!e_found && bus.req_new_request[i]) begin
        e_found = 1'b1;
        e_win   = i;
      end
    end
    e_ld    = bus.req_load[e_win];
    e_issue = e_found && !bus.lsq_full && !(e_ld && m_q.size() >= MAXO);
    e_grant = e_issue ? (4'b0001 << e_win) : 4'b0000;
    e_pop   = bus.lsq_load_complete && (m_q.size() > 0);
    e_lc    = e_pop ? (4'b0001 << m_q[0]) : 4'b0000;
  endfunction

  task automatic model_update();
    if (bus.lsq_load_complete && m_q.size() == 0) m_err = 1'b1;
    if (e_pop) m_q.delete(0);
    if (e_issue) begin
      if (e_ld) begin
        m_q.push_back(e_win);
        if (bus.req_store[e_win]) m_err = 1'b1;
      end
      m_ptr = (e_win + 1) % NREQ;
    end
  endtask

  task automatic clear_inputs();
    bus.req_addr          = '0;
    bus.req_data          = '0;
    bus.req_fn3           = '0;
    bus.req_load          = '0;
    bus.req_store         = '0;
    bus.req_new_request   = '0;
    bus.lsq_full          = 1'b0;
    bus.lsq_load_data     = '0;
    bus.lsq_load_complete = 1'b0;
  endtask

  task automatic set_req(input int i, input bit v, input bit ld, input bit st,
                         input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    bus.req_new_request[i]  = v;
    bus.req_load[i]         = ld;
    bus.req_store[i]        = st;
    bus.req_addr[i*32 +: 32] = a;
    bus.req_data[i*32 +: 32] = d;
    bus.req_fn3[i*3 +: 3]    = f;
  endtask

  // Inputs are driven at edge+1; outputs are sampled at edge+2
  task automatic settle();
    #1;
    predict();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    model_reset();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    bus.req_new_request   = '1;
    bus.req_load          = '1;
    bus.lsq_load_complete = 1'b1;
    #2;
    n_checks++;
    if (bus.req_grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", bus.req_grant);
    else n_pass++;
    n_checks++;
    if (bus.lsq_new_request !== 1'b0 || bus.lsq_load !== 1'b0 || bus.lsq_store !== 1'b0)
      $display("FAIL reset_lsq_flags: got nr=%b ld=%b st=%b want 0 0 0",
               bus.lsq_new_request, bus.lsq_load, bus.lsq_store);
    else n_pass++;
    n_checks++;
    if (bus.req_load_complete !== 4'b0000) $display("FAIL reset_complete: got %b want 0000", bus.req_load_complete);
    else n_pass++;
    n_checks++;
    if (outstanding !== 3'd0 || perr !== 1'b0)
      $display("FAIL reset_state: got outstanding=%0d err=%b want 0 0", outstanding, perr);
    else n_pass++;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_load();
    set_req(2, 1, 1, 0, 32'h100, 32'h0, 3'b010);
    settle();
    n_checks++;
    if (bus.lsq_new_request !== 1'b1 || bus.lsq_addr !== 32'h100 || bus.lsq_load !== 1'b1)
      $display("FAIL single_issue: got nr=%b addr=%h ld=%b want 1 00000100 1",
               bus.lsq_new_request, bus.lsq_addr, bus.lsq_load);
    else n_pass++;
    n_checks++;
    if (bus.req_grant !== 4'b0100) $display("FAIL single_grant: got %b want 0100", bus.req_grant);
    else n_pass++;
    tick();
    set_req(2, 0, 0, 0, 32'h0, 32'h0, 3'b000);
    n_checks++;
    if (outstanding !== 3'd1) $display("FAIL single_outstanding1: got %0d want 1", outstanding);
    else n_pass++;
    bus.lsq_load_complete = 1'b1;
    bus.lsq_load_data     = 32'hDEADBEEF;
    settle();
    n_checks++;
    if (bus.req_load_complete !== 4'b0100 || bus.req_load_data !== 32'hDEADBEEF)
      $display("FAIL single_return: got lc=%b data=%h want 0100 deadbeef",
               bus.req_load_complete, bus.req_load_data);
    else n_pass++;
    tick();
    bus.lsq_load_complete = 1'b0;
    n_checks++;
    if (outstanding !== 3'd0) $display("FAIL single_outstanding0: got %0d want 0", outstanding);
    else n_pass++;
  endtask

  task automatic test_store_rr();
    logic [3:0] exp;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 1, 32'h1000 + 32'(i*4), 32'hA0 + 32'(i), 3'b010);
    for (int k = 0; k < 8; k++) begin
      settle();
      exp = 4'b0001 << (k % 4);
      n_checks++;
      if (bus.req_grant !== exp || bus.lsq_data !== 32'hA0 + 32'(k % 4) || bus.lsq_store !== 1'b1)
        $display("FAIL store_rr cyc%0d: got grant=%b data=%h want %b %h",
                 k, bus.req_grant, bus.lsq_data, exp, 32'hA0 + 32'(k % 4));
      else n_pass++;
      tick();
    end
    clear_inputs();
    n_checks++;
    if (outstanding !== 3'd0) $display("FAIL store_no_tags: got %0d want 0", outstanding);
    else n_pass++;
  endtask

  task automatic test_alt_loads();
    logic [3:0] exp;
    apply_reset();
    set_req(0, 1, 1, 0, 32'h200, 32'h0, 3'b010);
    set_req(3, 1, 1, 0, 32'h300, 32'h0, 3'b010);
    for (int k = 0; k < 4; k++) begin
      settle();
      exp = (k % 2 == 0) ? 4'b0001 : 4'b1000;
      n_checks++;
      if (bus.req_grant !== exp) $display("FAIL alt_grant cyc%0d: got %b want %b", k, bus.req_grant, exp);
      else n_pass++;
      tick();
    end
    clear_inputs();
    n_checks++;
    if (outstanding !== 3'd4) $display("FAIL alt_outstanding: got %0d want 4", outstanding);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      bus.lsq_load_complete = 1'b1;
      bus.lsq_load_data     = 32'h5000 + 32'(k);
      settle();
      exp = (k % 2 == 0) ? 4'b0001 : 4'b1000;
      n_checks++;
      if (bus.req_load_complete !== exp || bus.req_load_data !== 32'h5000 + 32'(k))
        $display("FAIL alt_return cyc%0d: got %b %h want %b %h",
                 k, bus.req_load_complete, bus.req_load_data, exp, 32'h5000 + 32'(k));
      else n_pass++;
      tick();
    end
    bus.lsq_load_complete = 1'b0;
  endtask

  task automatic test_fifo_full();
    apply_reset();
    set_req(0, 1, 1, 0, 32'h400, 32'h0, 3'b010);
    for (int k = 0; k < 4; k++) begin
      settle();
      n_checks++;
      if (bus.req_grant !== 4'b0001) $display("FAIL fill_grant cyc%0d: got %b want 0001", k, bus.req_grant);
      else n_pass++;
      tick();
    end
    set_req(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
    set_req(1, 1, 1, 0, 32'h500, 32'h0, 3'b010);
    set_req(2, 1, 0, 1, 32'h600, 32'h66, 3'b010);
    settle();
    n_checks++;
    if (bus.req_grant !== 4'b0000 || bus.lsq_new_request !== 1'b0 || outstanding !== 3'd4)
      $display("FAIL full_block: got grant=%b nr=%b outstanding=%0d want 0000 0 4",
               bus.req_grant, bus.lsq_new_request, outstanding);
    else n_pass++;
    tick();
    bus.lsq_load_complete = 1'b1;
    settle();
    n_checks++;
    if (bus.req_grant !== 4'b0000 || bus.req_load_complete !== 4'b0001)
      $display("FAIL full_pop_same_cycle: got grant=%b lc=%b want 0000 0001",
               bus.req_grant, bus.req_load_complete);
    else n_pass++;
    tick();
    bus.lsq_load_complete = 1'b0;
    settle();
    n_checks++;
    if (bus.req_grant !== 4'b0010 || outstanding !== 3'd3)
      $display("FAIL full_release: got grant=%b outstanding=%0d want 0010 3", bus.req_grant, outstanding);
    else n_pass++;
    tick();
    set_req(1, 0, 0, 0, 32'h0, 32'h0, 3'b000);
    settle();
    n_checks++;
    if (bus.req_grant !== 4'b0100 || outstanding !== 3'd4)
      $display("FAIL full_store_pass: got grant=%b outstanding=%0d want 0100 4", bus.req_grant, outstanding);
    else n_pass++;
    tick();
    clear_inputs();
  endtask

  task automatic test_lsq_full();
    apply_reset();
    set_req(1, 1, 0, 1, 32'h700, 32'h77, 3'b001);
    bus.lsq_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_checks++;
      if (bus.req_grant !== 4'b0000 || bus.lsq_new_request !== 1'b0)
        $display("FAIL lsq_full_stall cyc%0d: got grant=%b nr=%b want 0000 0", k, bus.req_grant, bus.lsq_new_request);
      else n_pass++;
      tick();
    end
    bus.lsq_full = 1'b0;
    settle();
    n_checks++;
    if (bus.req_grant !== 4'b0010 || bus.lsq_addr !== 32'h700)
      $display("FAIL lsq_full_release: got grant=%b addr=%h want 0010 00000700", bus.req_grant, bus.lsq_addr);
    else n_pass++;
    tick();
    clear_inputs();
  endtask

  task automatic test_errors();
    apply_reset();
    bus.lsq_load_complete = 1'b1;
    settle();
    n_checks++;
    if (bus.req_load_complete !== 4'b0000) $display("FAIL empty_complete: got %b want 0000", bus.req_load_complete);
    else n_pass++;
    tick();
    bus.lsq_load_complete = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      tick();
    end
    n_checks++;
    if (perr !== 1'b1) $display("FAIL err_sticky: got %b want 1", perr);
    else n_pass++;
    apply_reset();
    set_req(1, 1, 1, 1, 32'h800, 32'h88, 3'b010);
    settle();
    n_checks++;
    if (bus.req_grant !== 4'b0010 || bus.lsq_load !== 1'b1 || bus.lsq_store !== 1'b1 || perr !== 1'b0)
      $display("FAIL both_flags: got grant=%b ld=%b st=%b err=%b want 0010 1 1 0",
               bus.req_grant, bus.lsq_load, bus.lsq_store, perr);
    else n_pass++;
    tick();
    clear_inputs();
    n_checks++;
    if (outstanding !== 3'd1 || perr !== 1'b1)
      $display("FAIL both_tagged: got outstanding=%0d err=%b want 1 1", outstanding, perr);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_req(0, 1, 1, 0, 32'h900, 32'h0, 3'b010);
    set_req(1, 1, 1, 0, 32'h904, 32'h0, 3'b010);
    settle();
    tick();
    settle();
    tick();
    n_checks++;
    if (outstanding !== 3'd2) $display("FAIL mid_pre: got %0d want 2", outstanding);
    else n_pass++;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (outstanding !== 3'd0 || perr !== 1'b0 || bus.req_grant !== 4'b0000 || bus.lsq_new_request !== 1'b0)
      $display("FAIL mid_reset: got outstanding=%0d err=%b grant=%b nr=%b want 0 0 0000 0",
               outstanding, perr, bus.req_grant, bus.lsq_new_request);
    else n_pass++;
    clear_inputs();
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.lsq_load_complete = 1'b1;
    settle();
    n_checks++;
    if (bus.req_load_complete !== 4'b0000) $display("FAIL mid_stale_complete: got %b want 0000", bus.req_load_complete);
    else n_pass++;
    tick();
    bus.lsq_load_complete = 1'b0;
    n_checks++;
    if (perr !== 1'b1) $display("FAIL mid_stale_err: got %b want 1", perr);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0]  last_grant;
    logic [31:0] exp_addr;
    bit          ld;
    bit          st;
    apply_reset();
    last_grant = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_new_request[i] || last_grant[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            ld = ($urandom_range(9, 0) < 6);
            st = !ld || ($urandom_range(31, 0) == 0);
            set_req(i, 1, ld, st, $urandom, $urandom, 3'($urandom_range(7, 0)));
          end else begin
            set_req(i, 0, 0, 0, 32'h0, 32'h0, 3'b000);
          end
        end
      end
      bus.lsq_full          = ($urandom_range(3, 0) == 0);
      bus.lsq_load_complete = (m_q.size() > 0) ? ($urandom_range(1, 0) == 1) : ($urandom_range(39, 0) == 0);
      bus.lsq_load_data     = $urandom;
      settle();
      exp_addr = bus.req_addr[e_win*32 +: 32];
      n_checks++;
      if (bus.req_grant !== e_grant || bus.lsq_new_request !== e_issue)
        $display("FAIL rand_grant cyc%0d: got grant=%b nr=%b want %b %b",
                 cyc, bus.req_grant, bus.lsq_new_request, e_grant, e_issue);
      else n_pass++;
      if (e_found) begin
        n_checks++;
        if (bus.lsq_addr !== exp_addr) $display("FAIL rand_addr cyc%0d: got %h want %h", cyc, bus.lsq_addr, exp_addr);
        else n_pass++;
      end
      n_checks++;
      if (bus.req_load_complete !== e_lc) $display("FAIL rand_complete cyc%0d: got %b want %b", cyc, bus.req_load_complete, e_lc);
      else n_pass++;
      n_checks++;
      if (outstanding !== 3'(m_q.size()) || perr !== m_err)
        $display("FAIL rand_state cyc%0d: got outstanding=%0d err=%b want %0d %b",
                 cyc, outstanding, perr, m_q.size(), m_err);
      else n_pass++;
      last_grant = e_grant;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_load();
    test_store_rr();
    test_alt_loads();
    test_fifo_full();
    test_lsq_full();
    test_errors();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
